// File: rtl/player_motion.sv
// Vertical-motion engine for the jetpack sprite: ticked velocity integration under
// gravity/thrust, ceiling/floor clamping, and IDLE/FLY/DEAD sequencing.
module player_motion #(
   parameter int Y_WIDTH     = 9,
   parameter int V_WIDTH     = 6,
   parameter int SCREEN_H    = 480,
   parameter int SPRITE_H    = 60,
   parameter int Y_START     = 210,
   parameter int GRAVITY     = 1,
   parameter int THRUST      = 2,
   parameter int V_MAX       = 8,
   parameter int TICK_CYCLES = 400000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in,
   input  logic               game_over,
   output logic [Y_WIDTH-1:0] y0,
   output logic [V_WIDTH-1:0] vel,
   output logic [1:0]         state,
   output logic               on_floor,
   output logic               on_ceiling,
   output logic               tick
);

   localparam int CNT_W = $clog2(TICK_CYCLES);
   localparam int PW    = Y_WIDTH + 2;

   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TICK_CYCLES - 1);
   localparam logic [Y_WIDTH-1:0]   Y_MAX    = Y_WIDTH'(SCREEN_H - SPRITE_H);
   localparam logic [Y_WIDTH-1:0]   Y_INIT   = Y_WIDTH'(Y_START);
   localparam logic signed [PW-1:0] YMAX_S   = PW'(SCREEN_H - SPRITE_H);
   localparam logic signed [PW-1:0] GRAV_S   = PW'(GRAVITY);
   localparam logic signed [PW-1:0] THR_S    = PW'(THRUST);
   localparam logic signed [PW-1:0] VMAX_S   = PW'(V_MAX);
   localparam logic signed [PW-1:0] VMIN_S   = -VMAX_S;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      FLY  = 2'b01,
      DEAD = 2'b10
   } state_t;

   state_t               state_q, state_n;
   logic [CNT_W-1:0]     cnt;
   logic                 in_q;
   logic                 press;
   logic [Y_WIDTH-1:0]   y0_q, y0_n;
   logic [V_WIDTH-1:0]   vel_q, vel_n;

   logic signed [PW-1:0] vel_ext, v_raw, v_sat, y_ext, y_new;
   logic [Y_WIDTH-1:0]   phys_y;
   logic [V_WIDTH-1:0]   phys_v;

   assign tick  = (cnt == CNT_LAST);
   assign press = in & ~in_q;

   // NOTE: all registered state uses non-blocking (<=) so every flop samples the
   // pre-edge values of its neighbours; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         in_q    <= 1'b0;
         state_q <= IDLE;
         y0_q    <= Y_INIT;
         vel_q   <= '0;
      end else begin
         cnt     <= tick ? '0 : cnt + CNT_W'(1);
         in_q    <= in;
         state_q <= state_n;
         y0_q    <= y0_n;
         vel_q   <= vel_n;
      end
   end

   // Physics candidate, evaluated every cycle and committed only on a FLY tick.
   always_comb begin
      vel_ext = {{(PW-V_WIDTH){vel_q[V_WIDTH-1]}}, vel_q};
      v_raw   = in ? (vel_ext - THR_S) : (vel_ext + GRAV_S);
      v_sat   = v_raw;
      if (v_raw > VMAX_S)      v_sat = VMAX_S;
      else if (v_raw < VMIN_S) v_sat = VMIN_S;
      y_ext   = {2'b00, y0_q};
      y_new   = y_ext + v_sat;
      phys_y  = y_new[Y_WIDTH-1:0];
      phys_v  = v_sat[V_WIDTH-1:0];
      if (y_new >= YMAX_S) begin
         phys_y = Y_MAX;
         if (!v_sat[PW-1] && (v_sat != '0)) phys_v = '0;
      end else if (y_new[PW-1] || (y_new == '0)) begin
         phys_y = '0;
         if (v_sat[PW-1]) phys_v = '0;
      end
   end

   // NOTE: every output of this block is given a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_n = state_q;
      y0_n    = y0_q;
      vel_n   = vel_q;
      unique case (state_q)
         IDLE: begin
            y0_n  = Y_INIT;
            vel_n = '0;
            if (press) state_n = FLY;
         end
         FLY: begin
            if (game_over) begin
               state_n = DEAD;
            end else if (tick) begin
               y0_n  = phys_y;
               vel_n = phys_v;
            end
         end
         DEAD: begin
            if (press) begin
               state_n = IDLE;
               y0_n    = Y_INIT;
               vel_n   = '0;
            end
         end
         default: begin
            state_n = IDLE;
            y0_n    = Y_INIT;
            vel_n   = '0;
         end
      endcase
   end

   assign y0         = y0_q;
   assign vel        = vel_q;
   assign state      = state_q;
   assign on_floor   = (y0_q == Y_MAX);
   assign on_ceiling = (y0_q == '0);

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion with a 4-cycle physics tick; expected values
// are hand-computed from the motion rules.
module tb_player_motion;

   logic       clk = 1'b0;
   logic       reset, in, game_over;
   logic [8:0] y0;
   logic [5:0] vel;
   logic [1:0] state;
   logic       on_floor, on_ceiling, tick;

   int n_vec = 0;
   int n_err = 0;

   int fall_y [9] = '{211, 213, 216, 220, 225, 231, 238, 246, 254};
   int fall_v [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 8};
   int thr_y  [5] = '{418, 414, 408, 400, 392};
   int thr_v  [5] = '{-2, -4, -6, -8, -8};

   player_motion #(.TICK_CYCLES(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .in         (in),
      .game_over  (game_over),
      .y0         (y0),
      .vel        (vel),
      .state      (state),
      .on_floor   (on_floor),
      .on_ceiling (on_ceiling),
      .tick       (tick)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_pos(input string tag, input int y, input int v);
      check({tag, "_y0"}, {23'd0, y0}, y);
      check({tag, "_vel"}, $signed(vel), v);
   endtask

   // Advance until tick is high (bounded), leaving the tick edge still to come.
   task automatic wait_tick();
      int n = 0;
      while (tick !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      check("tick_wait", {31'd0, tick}, 1);
   endtask

   task automatic do_tick();
      wait_tick();
      step();
   endtask

   initial begin
      reset = 1'b1; in = 1'b0; game_over = 1'b0;
      step();
      step();
      reset = 1'b0;
      check_pos("reset", 210, 0);
      check("reset_state", {30'd0, state}, 0);
      check("reset_tick", {31'd0, tick}, 0);
      check("reset_floor", {31'd0, on_floor}, 0);
      check("reset_ceiling", {31'd0, on_ceiling}, 0);

      for (int i = 1; i <= 20; i++) begin
         step();
         check("idle_tick", {31'd0, tick}, (i % 4 == 3) ? 1 : 0);
      end
      check_pos("idle", 210, 0);
      check("idle_state", {30'd0, state}, 0);

      // Single-cycle press starts flight; free fall with gravity only.
      in = 1'b1;
      step();
      in = 1'b0;
      check("start_state", {30'd0, state}, 1);
      check_pos("start", 210, 0);
      for (int k = 0; k < 9; k++) begin
         do_tick();
         check_pos("fall", fall_y[k], fall_v[k]);
      end
      for (int k = 0; k < 20; k++) do_tick();
      check_pos("near_floor", 414, 8);
      do_tick();
      check_pos("floor", 420, 0);
      check("floor_flag", {31'd0, on_floor}, 1);
      check("floor_ceiling_flag", {31'd0, on_ceiling}, 0);
      do_tick();
      check_pos("floor_hold", 420, 0);

      // Hold thrust from the floor up to the ceiling.
      in = 1'b1;
      for (int k = 0; k < 5; k++) begin
         do_tick();
         check_pos("thrust", thr_y[k], thr_v[k]);
      end
      for (int k = 0; k < 48; k++) do_tick();
      check_pos("near_ceiling", 8, -8);
      do_tick();
      check_pos("ceiling", 0, 0);
      check("ceiling_flag", {31'd0, on_ceiling}, 1);
      check("ceiling_floor_flag", {31'd0, on_floor}, 0);
      do_tick();
      check_pos("ceiling_hold", 0, 0);

      in = 1'b0;
      do_tick();
      check_pos("drop1", 1, 1);
      do_tick();
      check_pos("drop2", 3, 2);
      do_tick();
      check_pos("drop3", 6, 3);

      // game_over on a tick cycle wins over the physics update.
      wait_tick();
      game_over = 1'b1;
      step();
      check("dead_state", {30'd0, state}, 2);
      check_pos("dead", 6, 3);
      for (int j = 0; j < 4; j++) begin
         repeat (10) step();
         check_pos("dead_frozen", 6, 3);
         check("dead_hold_state", {30'd0, state}, 2);
      end

      // Press while game_over is still high returns to IDLE.
      in = 1'b1;
      step();
      in = 1'b0;
      check("restart_state", {30'd0, state}, 0);
      check_pos("restart", 210, 0);
      repeat (8) step();
      check("idle_ignores_game_over", {30'd0, state}, 0);
      check_pos("idle_after_restart", 210, 0);
      game_over = 1'b0;

      // Mid-flight synchronous reset.
      in = 1'b1;
      step();
      in = 1'b0;
      check("refly_state", {30'd0, state}, 1);
      for (int k = 0; k < 5; k++) do_tick();
      check_pos("midflight", 225, 5);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_pos("midreset", 210, 0);
      check("midreset_state", {30'd0, state}, 0);
      check("midreset_tick0", {31'd0, tick}, 0);
      step();
      check("midreset_tick1", {31'd0, tick}, 0);
      step();
      check("midreset_tick2", {31'd0, tick}, 0);
      step();
      check("midreset_tick3", {31'd0, tick}, 1);
      check("midreset_idle", {30'd0, state}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
